// File: rtl/axi_ic_pkg.sv
// Shared types for the AXI interconnect write-response path.
package axi_ic_pkg;

   localparam int RESP_W = 2;

   typedef enum logic [RESP_W-1:0] {
      OKAY   = 2'b00,
      EXOKAY = 2'b01,
      SLVERR = 2'b10,
      DECERR = 2'b11
   } resp_t;

   typedef enum logic [1:0] {
      IDLE,
      WAIT_RESP,
      SEND
   } b_state_t;

endpackage

// File: rtl/resp_order_fifo.sv
// Order FIFO of {master, slave} pairs in W-completion order; head visible the cycle after push.
// Pushes while full are dropped (push_rdy = !full); pop must only be asserted when non-empty.
module resp_order_fifo #(
   parameter int Depth     = 4,
   parameter int M_ID_Size = 1,
   parameter int S_ID_Size = 2,
   parameter int CNT_W     = $clog2(Depth + 1)
) (
   input  logic                 ACLK,
   input  logic                 ARESET,
   input  logic                 push_vld,
   input  logic [M_ID_Size-1:0] push_mst,
   input  logic [S_ID_Size-1:0] push_slv,
   output logic                 push_rdy,
   input  logic                 pop,
   output logic [M_ID_Size-1:0] head_mst,
   output logic [S_ID_Size-1:0] head_slv,
   output logic                 full,
   output logic                 empty,
   output logic [CNT_W-1:0]     count
);

   localparam int AW    = $clog2(Depth);
   localparam int PTR_W = AW + 1;

   logic [PTR_W-1:0]     wr_ptr;
   logic [PTR_W-1:0]     rd_ptr;
   logic [PTR_W-1:0]     diff;
   logic [M_ID_Size-1:0] mst_mem [Depth];
   logic [S_ID_Size-1:0] slv_mem [Depth];
   logic                 do_push;

   // MSB of each pointer is the wrap bit distinguishing full from empty
   assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign empty    = (wr_ptr == rd_ptr);
   assign diff     = wr_ptr - rd_ptr;
   assign count    = CNT_W'(diff);
   assign push_rdy = !full;
   assign do_push  = push_vld && !full;
   assign head_mst = mst_mem[rd_ptr[AW-1:0]];
   assign head_slv = slv_mem[rd_ptr[AW-1:0]];

   always_ff @(posedge ACLK) begin
      if (ARESET) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (do_push) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (pop && !empty) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
      end
   end

   always_ff @(posedge ACLK) begin
      if (do_push) begin
         mst_mem[wr_ptr[AW-1:0]] <= push_mst;
         slv_mem[wr_ptr[AW-1:0]] <= push_slv;
      end
   end

endmodule

// File: rtl/write_resp_router.sv
// B-channel router: returns each slave response to its issuing master in W-completion order.
// 1-cycle slave-to-master latency; one response per 3 cycles; non-head slaves stall on S_BREADY.
module write_resp_router
   import axi_ic_pkg::*;
#(
   parameter int Masters_Num = 2,
   parameter int Slaves_Num  = 2,
   parameter int Depth       = 4,
   parameter int M_ID_Size   = $clog2(Masters_Num),
   parameter int S_ID_Size   = $clog2(Slaves_Num) + 1
) (
   input  logic                          ACLK,
   input  logic                          ARESET,
   input  logic                          Push_Valid,
   input  logic [M_ID_Size-1:0]          Push_Master_ID,
   input  logic [S_ID_Size-1:0]          Push_Slave_ID,
   output logic                          Push_Ready,
   input  logic [Slaves_Num-1:0]         S_BVALID,
   input  logic [RESP_W*Slaves_Num-1:0]  S_BRESP,
   output logic [Slaves_Num-1:0]         S_BREADY,
   output logic [Masters_Num-1:0]        M_BVALID,
   output logic [RESP_W*Masters_Num-1:0] M_BRESP,
   input  logic [Masters_Num-1:0]        M_BREADY,
   output logic                          Queue_Is_Full,
   output logic                          Queue_Is_Empty,
   output logic [$clog2(Depth+1)-1:0]    Outstanding_Count
);

   b_state_t             state_q;
   b_state_t             state_d;
   logic [M_ID_Size-1:0] head_mst;
   logic [S_ID_Size-1:0] head_slv;
   logic                 head_in_range;
   logic                 head_bvalid;
   resp_t                head_bresp;
   logic                 mst_bready;
   logic                 pop;
   logic                 load;
   resp_t                load_resp;
   logic [M_ID_Size-1:0] mst_q;
   resp_t                resp_q;

   resp_order_fifo #(
      .Depth     (Depth),
      .M_ID_Size (M_ID_Size),
      .S_ID_Size (S_ID_Size),
      .CNT_W     ($clog2(Depth+1))
   ) u_order (
      .ACLK     (ACLK),
      .ARESET   (ARESET),
      .push_vld (Push_Valid),
      .push_mst (Push_Master_ID),
      .push_slv (Push_Slave_ID),
      .push_rdy (Push_Ready),
      .pop      (pop),
      .head_mst (head_mst),
      .head_slv (head_slv),
      .full     (Queue_Is_Full),
      .empty    (Queue_Is_Empty),
      .count    (Outstanding_Count)
   );

   assign head_in_range = (head_slv < S_ID_Size'(Slaves_Num));

   // Only the head slave's channel is ever looked at; others wait their turn
   always_comb begin
      head_bvalid = 1'b0;
      head_bresp  = OKAY;
      for (int i = 0; i < Slaves_Num; i++) begin
         if (head_slv == S_ID_Size'(i)) begin
            head_bvalid = S_BVALID[i];
            head_bresp  = resp_t'(S_BRESP[RESP_W*i +: RESP_W]);
         end
      end
   end

   always_comb begin
      mst_bready = 1'b0;
      for (int j = 0; j < Masters_Num; j++) begin
         if (mst_q == M_ID_Size'(j)) begin
            mst_bready = M_BREADY[j];
         end
      end
   end

   always_ff @(posedge ACLK) begin
      if (ARESET) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      pop       = 1'b0;
      load      = 1'b0;
      load_resp = DECERR;
      case (state_q)
         IDLE: begin
            if (!Queue_Is_Empty) begin
               if (head_in_range) begin
                  state_d = WAIT_RESP;
               end else begin
                  pop       = 1'b1;
                  load      = 1'b1;
                  load_resp = DECERR;
                  state_d   = SEND;
               end
            end
         end
         WAIT_RESP: begin
            if (head_bvalid) begin
               pop       = 1'b1;
               load      = 1'b1;
               load_resp = head_bresp;
               state_d   = SEND;
            end
         end
         SEND: begin
            if (mst_bready) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge ACLK) begin
      if (ARESET) begin
         mst_q  <= '0;
         resp_q <= OKAY;
      end else if (load) begin
         mst_q  <= head_mst;
         resp_q <= load_resp;
      end
   end

   always_comb begin
      S_BREADY = '0;
      M_BVALID = '0;
      M_BRESP  = '0;
      if (state_q == WAIT_RESP) begin
         for (int i = 0; i < Slaves_Num; i++) begin
            if (head_slv == S_ID_Size'(i)) begin
               S_BREADY[i] = 1'b1;
            end
         end
      end
      if (state_q == SEND) begin
         for (int j = 0; j < Masters_Num; j++) begin
            if (mst_q == M_ID_Size'(j)) begin
               M_BVALID[j]                    = 1'b1;
               M_BRESP[RESP_W*j +: RESP_W] = resp_q;
            end
         end
      end
   end

endmodule

// File: tb/tb_write_resp_router.sv
// Directed bench for write_resp_router; a negedge monitor scores master handshakes against a queue.
module tb_write_resp_router;

   logic       ACLK;
   logic       ARESET;
   logic       Push_Valid;
   logic       Push_Master_ID;
   logic [1:0] Push_Slave_ID;
   logic       Push_Ready;
   logic [1:0] S_BVALID;
   logic [3:0] S_BRESP;
   logic [1:0] S_BREADY;
   logic [1:0] M_BVALID;
   logic [3:0] M_BRESP;
   logic [1:0] M_BREADY;
   logic       Queue_Is_Full;
   logic       Queue_Is_Empty;
   logic [2:0] Outstanding_Count;

   write_resp_router #(
      .Masters_Num (2),
      .Slaves_Num  (2),
      .Depth       (4)
   ) dut (
      .ACLK              (ACLK),
      .ARESET            (ARESET),
      .Push_Valid        (Push_Valid),
      .Push_Master_ID    (Push_Master_ID),
      .Push_Slave_ID     (Push_Slave_ID),
      .Push_Ready        (Push_Ready),
      .S_BVALID          (S_BVALID),
      .S_BRESP           (S_BRESP),
      .S_BREADY          (S_BREADY),
      .M_BVALID          (M_BVALID),
      .M_BRESP           (M_BRESP),
      .M_BREADY          (M_BREADY),
      .Queue_Is_Full     (Queue_Is_Full),
      .Queue_Is_Empty    (Queue_Is_Empty),
      .Outstanding_Count (Outstanding_Count)
   );

   typedef struct {
      int         mst;
      logic [1:0] resp;
   } exp_t;

   exp_t sb[$];
   exp_t mon_e;
   int   n_cmp = 0;
   int   n_err = 0;

   initial ACLK = 1'b0;
   always #5 ACLK = ~ACLK;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge ACLK);
      #1;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic expect_resp(input int mst, input logic [1:0] resp);
      exp_t e;
      e.mst  = mst;
      e.resp = resp;
      sb.push_back(e);
   endtask

   // Scores every master handshake in the order it happens
   always @(negedge ACLK) begin
      if (!ARESET) begin
         for (int j = 0; j < 2; j++) begin
            if (M_BVALID[j] && M_BREADY[j]) begin
               n_cmp++;
               if (sb.size() == 0) begin
                  n_err++;
                  $display("FAIL unexpected_resp: master %0d resp %0b with nothing expected", j, M_BRESP[2*j +: 2]);
               end else begin
                  mon_e = sb.pop_front();
                  if (mon_e.mst != j || M_BRESP[2*j +: 2] !== mon_e.resp) begin
                     n_err++;
                     $display("FAIL resp_route: got master %0d resp %0b expected master %0d resp %0b",
                              j, M_BRESP[2*j +: 2], mon_e.mst, mon_e.resp);
                  end
               end
            end
         end
      end
   end

   initial begin
      ARESET         = 1'b1;
      Push_Valid     = 1'b0;
      Push_Master_ID = 1'b0;
      Push_Slave_ID  = 2'd0;
      S_BVALID       = 2'b00;
      S_BRESP        = 4'b0000;
      M_BREADY       = 2'b00;
      tick();
      tick();
      ARESET = 1'b0;

      chk("rst_empty", 32'(Queue_Is_Empty), 32'd1);
      chk("rst_full", 32'(Queue_Is_Full), 32'd0);
      chk("rst_push_ready", 32'(Push_Ready), 32'd1);
      chk("rst_count", 32'(Outstanding_Count), 32'd0);
      chk("rst_s_bready", 32'(S_BREADY), 32'd0);
      chk("rst_m_bvalid", 32'(M_BVALID), 32'd0);
      chk("rst_m_bresp", 32'(M_BRESP), 32'd0);

      // Single write {m1, s0}
      Push_Valid = 1'b1; Push_Master_ID = 1'b1; Push_Slave_ID = 2'd0;
      tick();
      Push_Valid = 1'b0;
      chk("single_count", 32'(Outstanding_Count), 32'd1);
      chk("single_bready_idle", 32'(S_BREADY), 32'd0);
      tick();
      chk("single_bready", 32'(S_BREADY), 32'b01);
      S_BVALID = 2'b01; S_BRESP = 4'b0000;
      expect_resp(1, 2'b00);
      tick();
      S_BVALID = 2'b00;
      chk("single_mvalid", 32'(M_BVALID), 32'b10);
      chk("single_mresp", 32'(M_BRESP), 32'b0000);
      chk("single_bready_send", 32'(S_BREADY), 32'd0);
      chk("single_count_pop", 32'(Outstanding_Count), 32'd0);
      tick();
      chk("single_hold", 32'(M_BVALID), 32'b10);
      M_BREADY = 2'b10;
      tick();
      M_BREADY = 2'b00;
      chk("single_done", 32'(M_BVALID), 32'd0);

      // Ordering: {m0,s1} then {m1,s0}; both slaves valid together
      M_BREADY = 2'b11;
      S_BVALID = 2'b11; S_BRESP = 4'b0010;
      Push_Valid = 1'b1; Push_Master_ID = 1'b0; Push_Slave_ID = 2'd1;
      expect_resp(0, 2'b00);
      tick();
      Push_Master_ID = 1'b1; Push_Slave_ID = 2'd0;
      expect_resp(1, 2'b10);
      tick();
      Push_Valid = 1'b0;
      chk("order_bready_first", 32'(S_BREADY), 32'b10);
      tick();
      chk("order_mvalid_first", 32'(M_BVALID), 32'b01);
      chk("order_mresp_first", 32'(M_BRESP), 32'b0000);
      chk("order_bready_send", 32'(S_BREADY), 32'd0);
      tick();
      chk("order_idle_gap", 32'(S_BREADY), 32'd0);
      tick();
      chk("order_bready_second", 32'(S_BREADY), 32'b01);
      tick();
      chk("order_mvalid_second", 32'(M_BVALID), 32'b10);
      chk("order_mresp_second", 32'(M_BRESP), 32'b1000);
      tick();
      S_BVALID = 2'b00;
      chk("order_empty", 32'(Queue_Is_Empty), 32'd1);

      // Decode miss: {m0, slave 3} then {m1, slave 2}
      S_BVALID = 2'b11;
      Push_Valid = 1'b1; Push_Master_ID = 1'b0; Push_Slave_ID = 2'd3;
      expect_resp(0, 2'b11);
      tick();
      Push_Master_ID = 1'b1; Push_Slave_ID = 2'd2;
      expect_resp(1, 2'b11);
      chk("miss_no_mvalid_yet", 32'(M_BVALID), 32'd0);
      tick();
      Push_Valid = 1'b0;
      chk("miss_mvalid0", 32'(M_BVALID), 32'b01);
      chk("miss_mresp0", 32'(M_BRESP), 32'b0011);
      chk("miss_bready0", 32'(S_BREADY), 32'd0);
      tick();
      chk("miss_bready_idle", 32'(S_BREADY), 32'd0);
      tick();
      chk("miss_mvalid1", 32'(M_BVALID), 32'b10);
      chk("miss_mresp1", 32'(M_BRESP), 32'b1100);
      chk("miss_bready1", 32'(S_BREADY), 32'd0);
      tick();
      S_BVALID = 2'b00;
      M_BREADY = 2'b00;
      chk("miss_empty", 32'(Queue_Is_Empty), 32'd1);

      // Full: five pushes of {m1, s1}, no responses
      Push_Valid = 1'b1; Push_Master_ID = 1'b1; Push_Slave_ID = 2'd1;
      for (int k = 0; k < 4; k++) tick();
      chk("full_count", 32'(Outstanding_Count), 32'd4);
      chk("full_flag", 32'(Queue_Is_Full), 32'd1);
      chk("full_push_ready", 32'(Push_Ready), 32'd0);
      tick();
      Push_Valid = 1'b0;
      chk("full_drop", 32'(Outstanding_Count), 32'd4);
      S_BVALID = 2'b10; S_BRESP = 4'b0100;
      expect_resp(1, 2'b01);
      tick();
      S_BVALID = 2'b00;
      chk("full_pop_count", 32'(Outstanding_Count), 32'd3);
      chk("full_pop_flag", 32'(Queue_Is_Full), 32'd0);
      chk("full_exokay", 32'(M_BRESP), 32'b0100);
      M_BREADY = 2'b10;
      tick();
      M_BREADY = 2'b00;
      tick();
      // Push and pop in the same cycle
      Push_Valid = 1'b1; Push_Master_ID = 1'b0; Push_Slave_ID = 2'd0;
      S_BVALID = 2'b10; S_BRESP = 4'b0000;
      expect_resp(1, 2'b00);
      tick();
      Push_Valid = 1'b0; S_BVALID = 2'b00;
      chk("pushpop_count", 32'(Outstanding_Count), 32'd3);
      M_BREADY = 2'b10;
      tick();
      M_BREADY = 2'b00;
      tick();
      S_BVALID = 2'b10; S_BRESP = 4'b1000;
      tick();
      S_BVALID = 2'b00;
      chk("send_count", 32'(Outstanding_Count), 32'd2);

      // Backpressure: hold M_BREADY low for 5 cycles in SEND
      for (int k = 0; k < 5; k++) begin
         tick();
         chk("bp_mvalid", 32'(M_BVALID), 32'b10);
         chk("bp_mresp", 32'(M_BRESP), 32'b1000);
         chk("bp_bready", 32'(S_BREADY), 32'd0);
      end

      // Reset mid-operation: held response and 2 queued entries discarded
      ARESET = 1'b1;
      tick();
      ARESET = 1'b0;
      sb.delete();
      chk("rmid_mvalid", 32'(M_BVALID), 32'd0);
      chk("rmid_mresp", 32'(M_BRESP), 32'd0);
      chk("rmid_bready", 32'(S_BREADY), 32'd0);
      chk("rmid_empty", 32'(Queue_Is_Empty), 32'd1);
      chk("rmid_full", 32'(Queue_Is_Full), 32'd0);
      chk("rmid_count", 32'(Outstanding_Count), 32'd0);
      chk("rmid_push_ready", 32'(Push_Ready), 32'd1);
      tick();
      tick();
      chk("rmid_quiet", 32'(M_BVALID), 32'd0);

      chk("sb_drained", 32'(sb.size()), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
